aes_ctrl: RTL and testbench

AES_CTRL -- requirements
Module: aes_ctrl

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_ctrl_if.sv | 26 ++
 rtl/aes_ctrl_edge.sv | 19 +
 rtl/aes_ctrl.sv | 170 +++++++++++++++++
 tb/tb_aes_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES controller: command opcodes, FSM state encoding
// and the 128-bit block type.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    OP_LOAD_KEY = 2'b00,
    OP_ENC      = 2'b01,
    OP_DEC      = 2'b10,
    OP_RSVD     = 2'b11
  } cmd_op_t;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_KEY_WAIT = 3'd1;
  localparam logic [2:0] ST_ENC_RUN  = 3'd2;
  localparam logic [2:0] ST_DEC_RUN  = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

endpackage

// File: rtl/aes_ctrl_if.sv
// Command/response bus of the AES controller.
interface aes_ctrl_if;
  import aes_pkg::*;

  // Both channels use valid/ready: a transfer happens on the rising edge where
  // valid & ready are high; valid and its payload must hold until then.
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  block_t      cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  block_t      rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/aes_ctrl_edge.sv
// Rising-edge detector for a core done line; the history bit is registered
// and cleared by reset.
module aes_ctrl_edge (
  input  logic clk,
  input  logic reset,
  input  logic done,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= done;
  end

  assign rise = done & ~prev;

endmodule

// File: rtl/aes_ctrl.sv
// AES controller: sequences key loading and enc/dec core operations behind a
// command/response bus. Define AES_CTRL_TIMEOUT_EN to add a core watchdog.
module aes_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_SETTLE     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  aes_ctrl_if.slave  bus,
  output logic       set_new_key,
  output block_t     key_out,
  output logic       enc_start,
  output block_t     enc_text,
  input  logic       enc_done,
  input  block_t     enc_result,
  output logic       dec_start,
  output block_t     dec_text,
  input  logic       dec_done,
  input  block_t     dec_result,
  output logic       key_loaded,
  output state_t     fsm_state
);

  localparam int CNT_MAX = (KEY_SETTLE > TIMEOUT_CYCLES) ? KEY_SETTLE : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((KEY_SETTLE > 0) ? KEY_SETTLE - 1 : 0);
`ifdef AES_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rsp_valid_q;
  block_t           rsp_data_q;
  logic             rsp_err_q;
  logic             enc_rise;
  logic             dec_rise;

  aes_ctrl_edge u_enc_edge (.clk(clk), .reset(reset), .done(enc_done), .rise(enc_rise));
  aes_ctrl_edge u_dec_edge (.clk(clk), .reset(reset), .done(dec_done), .rise(dec_rise));

  // Gated by reset so the bus never looks ready while reset is held.
  assign bus.cmd_ready = (state == ST_IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign fsm_state     = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      set_new_key <= 1'b0;
      key_out     <= '0;
      enc_start   <= 1'b0;
      enc_text    <= '0;
      dec_start   <= 1'b0;
      dec_text    <= '0;
      key_loaded  <= 1'b0;
    end else begin
      set_new_key <= 1'b0;
      enc_start   <= 1'b0;
      dec_start   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            cnt <= '0;
            case (bus.cmd_op)
              OP_LOAD_KEY: begin
                key_out     <= bus.cmd_data;
                set_new_key <= 1'b1;
                state       <= ST_KEY_WAIT;
              end
              OP_ENC: begin
                if (key_loaded) begin
                  enc_text  <= bus.cmd_data;
                  enc_start <= 1'b1;
                  state     <= ST_ENC_RUN;
                end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  state       <= ST_RESP;
                end
              end
              OP_DEC: begin
                if (key_loaded) begin
                  dec_text  <= bus.cmd_data;
                  dec_start <= 1'b1;
                  state     <= ST_DEC_RUN;
                end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  state       <= ST_RESP;
                end
              end
              default: begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
                state       <= ST_RESP;
              end
            endcase
          end
        end
        ST_KEY_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            key_loaded  <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ENC_RUN: begin
          if (enc_rise) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= enc_result;
            rsp_err_q   <= 1'b0;
            state       <= ST_RESP;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_DEC_RUN: begin
          if (dec_rise) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= dec_result;
            rsp_err_q   <= 1'b0;
            state       <= ST_RESP;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctrl.sv
// Bench for aes_ctrl: stub enc/dec cores, a command-level reference model and
// an expected-response queue. Build with AES_CTRL_TIMEOUT_EN for the watchdog test.
module tb_aes_ctrl;
  import aes_pkg::*;

  localparam int KEY_SETTLE     = 2;
  localparam int TIMEOUT_CYCLES = 64;
  localparam block_t K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t PT_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam block_t CT_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_ctrl_if bus ();
  logic   set_new_key, enc_start, dec_start, key_loaded;
  block_t key_out, enc_text, dec_text, enc_result, dec_result;
  logic   enc_done, dec_done, core_enc_done, core_dec_done, stray_enc_done, stray_dec_done;
  state_t fsm_state;
  assign enc_done = core_enc_done | stray_enc_done;
  assign dec_done = core_dec_done | stray_dec_done;

  aes_ctrl #(.KEY_SETTLE(KEY_SETTLE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .set_new_key(set_new_key), .key_out(key_out),
    .enc_start(enc_start), .enc_text(enc_text), .enc_done(enc_done), .enc_result(enc_result),
    .dec_start(dec_start), .dec_text(dec_text), .dec_done(dec_done), .dec_result(dec_result),
    .key_loaded(key_loaded), .fsm_state(fsm_state)
  );

  int errors = 0;
  int checks = 0;
  logic [128:0] exp_q[$];
  bit     m_loaded;
  block_t m_key;
  bit     core_hang;
  int     snk_hi, enc_hi, dec_hi;

  // Core behaviour: the FIPS-197 vector for its key, otherwise a keyed xor.
  function automatic block_t enc_fn(input block_t k, input block_t t);
    if (k == K_FIPS && t == PT_FIPS) return CT_FIPS;
    return t ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic block_t dec_fn(input block_t k, input block_t t);
    if (k == K_FIPS && t == CT_FIPS) return PT_FIPS;
    return t ^ k ^ 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  endfunction

  // Reference model: expected {err, data} for one command.
  function automatic logic [128:0] model_exp(input logic [1:0] op, input block_t d);
    case (op)
      2'b00: begin m_key = d; m_loaded = 1'b1; return {1'b0, 128'b0}; end
      2'b01: return m_loaded ? {1'b0, enc_fn(m_key, d)} : {1'b1, 128'b0};
      2'b10: return m_loaded ? {1'b0, dec_fn(m_key, d)} : {1'b1, 128'b0};
      default: return {1'b1, 128'b0};
    endcase
  endfunction

  always @(negedge clk) begin
    if (set_new_key) snk_hi++;
    if (enc_start)   enc_hi++;
    if (dec_start)   dec_hi++;
  end

  initial begin
    block_t t, k;
    core_enc_done = 1'b0; enc_result = '0;
    forever begin
      @(negedge clk);
      if (enc_start && !core_hang) begin
        t = enc_text; k = key_out;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 enc_result = enc_fn(k, t); core_enc_done = 1'b1;
        @(posedge clk); #1 core_enc_done = 1'b0;
      end
    end
  end

  initial begin
    block_t t, k;
    core_dec_done = 1'b0; dec_result = '0;
    forever begin
      @(negedge clk);
      if (dec_start && !core_hang) begin
        t = dec_text; k = key_out;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 dec_result = dec_fn(k, t); core_dec_done = 1'b1;
        @(posedge clk); #1 core_dec_done = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_cmd(input logic [1:0] op, input block_t data, input int hold,
                         output logic [128:0] got, output bit timed_out,
                         output bit stable, output int lat);
    int n;
    timed_out = 1'b0; stable = 1'b1; got = 'x; n = 0;
    while (!bus.cmd_ready && n < 100) begin tick(1); n++; end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
    tick(1);
    bus.cmd_valid = 1'b0; bus.cmd_data = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!bus.rsp_valid && lat < 200) begin tick(1); lat++; end
    if (!bus.rsp_valid) begin timed_out = 1'b1; return; end
    got = {bus.rsp_err, bus.rsp_data};
    repeat (hold) begin
      tick(1);
      if ({bus.rsp_err, bus.rsp_data} !== got || bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0)
        stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic pulse_stray(input bit enc, input bit dec);
    stray_enc_done = enc; stray_dec_done = dec;
    tick(1);
    stray_enc_done = 1'b0; stray_dec_done = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || key_loaded !== 1'b0 ||
        set_new_key !== 1'b0 || enc_start !== 1'b0 || dec_start !== 1'b0 ||
        key_out !== '0 || enc_text !== '0 || dec_text !== '0 || bus.rsp_data !== '0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b key_loaded=%b key_out=%h required all zero",
               bus.cmd_ready, bus.rsp_valid, key_loaded, key_out);
    end
    reset = 1'b0; m_loaded = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || fsm_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b state=%0d required 1/IDLE", bus.cmd_ready, fsm_state);
    end
  endtask

  task automatic test_errors();
    logic [128:0] got, exp;
    bit to, st;
    int lat, e0, d0;
    logic [1:0] ops[3];
    ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      e0 = enc_hi; d0 = dec_hi;
      exp_q.push_back(model_exp(ops[i], PT_FIPS));
      run_cmd(ops[i], PT_FIPS, 0, got, to, st, lat);
      exp = exp_q.pop_front();
      checks++;
      if (to || got !== exp) begin
        errors++;
        $display("FAIL err_rsp op=%0d: got %h required %h (timeout=%0b)", ops[i], got, exp, to);
      end
      checks++;
      if (enc_hi != e0 || dec_hi != d0) begin
        errors++;
        $display("FAIL err_no_start op=%0d: start pulses enc=%0d dec=%0d required 0", ops[i], enc_hi - e0, dec_hi - d0);
      end
    end
  endtask

  task automatic test_load_key();
    logic [128:0] got, exp;
    bit to, st;
    int lat, s0;
    s0 = snk_hi;
    exp_q.push_back(model_exp(2'b00, K_FIPS));
    run_cmd(2'b00, K_FIPS, 0, got, to, st, lat);
    exp = exp_q.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++; $display("FAIL load_rsp: got %h required %h", got, exp);
    end
    checks++;
    if (snk_hi - s0 != 1) begin
      errors++; $display("FAIL load_set_new_key: high cycles %0d required 1", snk_hi - s0);
    end
    checks++;
    if (lat != KEY_SETTLE) begin
      errors++; $display("FAIL load_settle: latency %0d required %0d", lat, KEY_SETTLE);
    end
    checks++;
    if (key_loaded !== 1'b1 || key_out !== K_FIPS) begin
      errors++; $display("FAIL load_key_out: key_loaded=%b key_out=%h required 1/%h", key_loaded, key_out, K_FIPS);
    end
  endtask

  task automatic test_enc_known();
    logic [128:0] got, exp;
    bit to, st;
    int lat, e0, d0;
    e0 = enc_hi; d0 = dec_hi;
    exp_q.push_back(model_exp(2'b01, PT_FIPS));
    run_cmd(2'b01, PT_FIPS, 0, got, to, st, lat);
    exp = exp_q.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++; $display("FAIL enc_fips: got %h required %h", got, exp);
    end
    checks++;
    if (enc_hi - e0 != 1 || dec_hi != d0) begin
      errors++; $display("FAIL enc_start_pulse: enc=%0d dec=%0d required 1/0", enc_hi - e0, dec_hi - d0);
    end
  endtask

  task automatic test_dec_hold();
    logic [128:0] got, exp;
    bit to, st;
    int lat, d0;
    d0 = dec_hi;
    exp_q.push_back(model_exp(2'b10, CT_FIPS));
    run_cmd(2'b10, CT_FIPS, 5, got, to, st, lat);
    exp = exp_q.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++; $display("FAIL dec_fips: got %h required %h", got, exp);
    end
    checks++;
    if (!st) begin
      errors++; $display("FAIL dec_hold: response or cmd_ready changed during hold (stable=%0b required 1)", st);
    end
    checks++;
    if (dec_hi - d0 != 1) begin
      errors++; $display("FAIL dec_start_pulse: %0d required 1", dec_hi - d0);
    end
  endtask

  task automatic test_stray_idle();
    pulse_stray(1'b1, 1'b1);
    tick(3);
    checks++;
    if (bus.rsp_valid !== 1'b0 || fsm_state !== ST_IDLE || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL stray_idle: rsp_valid=%b state=%0d required 0/IDLE", bus.rsp_valid, fsm_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [128:0] r[2];
    logic [128:0] exp;
    block_t k2, x;
    int nresp, n;
    bit viol, acc_next;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    x  = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model_exp(2'b00, k2));
    exp_q.push_back(model_exp(2'b01, x));
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin tick(1); n++; end
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_data = k2;
    tick(1);
    bus.cmd_op = 2'b01; bus.cmd_data = x;
    nresp = 0; viol = 1'b0; acc_next = 1'b0; n = 0;
    while (nresp < 2 && n < 300) begin
      if (bus.cmd_ready && bus.rsp_valid) viol = 1'b1;
      if (bus.cmd_ready && bus.cmd_valid) acc_next = 1'b1;
      if (bus.rsp_valid) begin r[nresp] = {bus.rsp_err, bus.rsp_data}; nresp++; end
      tick(1); n++;
      if (acc_next) begin bus.cmd_valid = 1'b0; acc_next = 1'b0; end
    end
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    checks++;
    if (nresp != 2 || viol) begin
      errors++; $display("FAIL b2b_flow: responses=%0d overlap=%0b required 2/0", nresp, viol);
    end
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (i < nresp && r[i] !== exp) begin
        errors++; $display("FAIL b2b_rsp%0d: got %h required %h", i, r[i], exp);
      end else if (i >= nresp) begin
        errors++; $display("FAIL b2b_rsp%0d: missing, required %h", i, exp);
      end
    end
    tick(1);
  endtask

  task automatic test_random();
    logic [128:0] got, exp;
    bit to, st;
    int lat, e0, d0, s0, hold;
    logic [1:0] op;
    block_t d;
    bit was_loaded;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      d = {$urandom, $urandom, $urandom, $urandom};
      if (op == 2'b00 && $urandom_range(0, 1) == 1) d = K_FIPS;
      hold = $urandom_range(0, 3);
      was_loaded = m_loaded;
      e0 = enc_hi; d0 = dec_hi; s0 = snk_hi;
      exp_q.push_back(model_exp(op, d));
      run_cmd(op, d, hold, got, to, st, lat);
      exp = exp_q.pop_front();
      checks++;
      if (to || got !== exp || !st) begin
        errors++; $display("FAIL rand%0d op=%0d: got %h required %h stable=%0b", i, op, got, exp, st);
      end
      checks++;
      if (enc_hi - e0 != ((op == 2'b01 && was_loaded) ? 1 : 0) ||
          dec_hi - d0 != ((op == 2'b10 && was_loaded) ? 1 : 0) ||
          snk_hi - s0 != ((op == 2'b00) ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_pulses op=%0d: enc=%0d dec=%0d key=%0d", i, op, enc_hi - e0, dec_hi - d0, snk_hi - s0);
      end
    end
  endtask

`ifdef AES_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [128:0] got, exp;
    bit to, st;
    int lat;
    core_hang = 1'b1;
    exp_q.push_back({1'b1, 128'b0});
    run_cmd(2'b01, PT_FIPS, 0, got, to, st, lat);
    exp = exp_q.pop_front();
    checks++;
    if (to || got !== exp || lat != TIMEOUT_CYCLES) begin
      errors++; $display("FAIL timeout: got %h after %0d cycles required %h after %0d", got, lat, exp, TIMEOUT_CYCLES);
    end
    core_hang = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_op();
    bit seen;
    int n;
    if (!m_loaded) begin
      logic [128:0] got;
      bit to, st;
      int lat;
      void'(model_exp(2'b00, K_FIPS));
      run_cmd(2'b00, K_FIPS, 0, got, to, st, lat);
    end
    core_hang = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin tick(1); n++; end
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_data = CT_FIPS;
    tick(1);
    bus.cmd_valid = 1'b0;
    tick(3);
    pulse_stray(1'b1, 1'b0);
    tick(3);
    checks++;
    if (fsm_state !== ST_DEC_RUN || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stray_enc_in_dec: state=%0d rsp_valid=%b required DEC_RUN/0", fsm_state, bus.rsp_valid);
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0; m_loaded = 1'b0;
    #1;
    checks++;
    if (fsm_state !== ST_IDLE || key_loaded !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_op: state=%0d key_loaded=%b cmd_ready=%b required IDLE/0/1", fsm_state, key_loaded, bus.cmd_ready);
    end
    tick(1);
    pulse_stray(1'b0, 1'b1);
    seen = 1'b0;
    repeat (5) begin if (bus.rsp_valid) seen = 1'b1; tick(1); end
    checks++;
    if (seen || fsm_state !== ST_IDLE) begin
      errors++; $display("FAIL stray_after_reset: rsp seen=%0b state=%0d required 0/IDLE", seen, fsm_state);
    end
    core_hang = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    stray_enc_done = 1'b0; stray_dec_done = 1'b0;
    core_hang = 1'b0; m_loaded = 1'b0; m_key = '0;
    snk_hi = 0; enc_hi = 0; dec_hi = 0;
    test_reset();
    test_errors();
    test_load_key();
    test_enc_known();
    test_dec_hold();
    test_stray_idle();
    test_back_to_back();
    test_random();
`ifdef AES_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
